alu_ex_seq: RTL
===============

# alu_ex_seq

Parametrised execute stage: register file, ALU, flags register and an iterative engine for multiply and multi-bit shifts. It replaces the single-cycle 16-bit execute stage, keeps the same 4-bit opcode map, and adds a valid/ready issue handshake so the decoder stalls while multi-cycle operations run. It sits between decode (operand indices, immediate) and the memory/PC logic (`mem_data`, `wr_pc`).

## Interface
Parameters:
- `WIDTH`, default 16: datapath, register and flags width; must be a power of two and at least 8.
- `NREGS`, default 8: register count, a power of two.
- `FLAGS_IDX`, default 2: register index aliased to the flags register.
- `PC_IDX`, default 3: register index whose write raises `wr_pc`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  stage can accept; an operation is accepted on `in_valid & in_ready`.
- `alu_f`  in  4  opcode.
- `a_idx`, `b_idx`, `d_idx`  in  log2(NREGS)  operand and destination indices.
- `wr_reg`  in  1  write result to `d_idx`.
- `wr_flags`  in  1  load {N,Z,V,C} into flags.
- `t16`  in  WIDTH  immediate.
- `sel_inp`  in  1  1 selects the immediate `t16` as operand B.
- `flags`  out  WIDTH  flags register.
- `d_val`  out  WIDTH  result; meaningful while `res_valid` is high.
- `mem_data`  out  WIDTH  `reg[b_idx]`, combinational.
- `wr_pc`  out  1  the committing result targets `PC_IDX`.
- `res_valid`  out  1  a commit happens at the next edge.

## Operation
- Operand B (`sel`) = `sel_inp ? t16 : reg[b_idx]`.
- Single-cycle opcodes:
  - 0 ADD, 1 MOV, 2 SUB, 3 CMP, 4 AND, 5 OR, 6 XOR, 7 TST.
  - 8 SEXT8: sign-extend `sel[7:0]`.
  - 9 NSWP: zero-extended `{sel[3:0],sel[7:4]}`.
  - A LSR1: C = `sel[0]`.
  - B LSL1: C = `sel[WIDTH-1]`.
  - F reserved: result 0, C 0.
- Multi-cycle opcodes:
  - C MUL: low half of `a*sel`. C = 1 if the high half is nonzero; V = 0.
  - D SHL and E SHR (logical): shift `a` by `n = sel[log2(WIDTH)-1:0]`. C = last bit shifted out; C = 0 when n = 0.
- Flags:
  - ADD/SUB carry is bit WIDTH of the (WIDTH+1)-bit result; for SUB it is the borrow.
  - V is computed for opcodes 0–3 only (signed overflow, B inverted for SUB/CMP); V = 0 otherwise.
  - Z = (result == 0); N = result MSB.
- Register writes:
  - CMP and TST never write a register.
  - Otherwise, `wr_reg` writes the result to `d_idx`.
  - A register write to `FLAGS_IDX` also loads `flags` with the full result.
  - `wr_flags` loads `{WIDTH-4 zeros, N, Z, V, C}` and wins over a register-write load of flags.
- `wr_pc = res_valid & wr_reg & (d_idx == PC_IDX) & ~CMP & ~TST`.
- FSM:
  - IDLE to BUSY on accepting a multi-cycle op. At accept, a, sel, opcode, `d_idx`, `wr_reg` and `wr_flags` are latched.
  - BUSY to DONE when the iteration count is exhausted.
  - DONE to IDLE after one cycle, during which the commit occurs.
  - `in_ready = (state == IDLE)`.

## Timing
- Reset values:
  - Register file and `flags` are 0; state is IDLE.
  - `in_ready` = 1; `res_valid`, `wr_pc` and `d_val` are 0.
- Single-cycle ops:
  - `res_valid = in_valid & in_ready` in the same cycle; `d_val` is combinational.
  - Commit happens at that edge.
  - The next op sees the written value; a same-cycle read sees the old value.
- MUL: WIDTH BUSY cycles (one shift-add per cycle), then DONE. Commit at the (WIDTH+1)-th edge after accept.
- SHL/SHR: n BUSY cycles, then DONE; n = 0 goes directly to DONE. Commit at the (n+1)-th edge after accept.
- During BUSY, `res_valid` = 0 and inputs are ignored. The register file is stable, so there are no hazards.
- Reset mid-operation aborts with no commit; `in_ready` = 1 in the first cycle after release.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL is as above.
- Without it: opcode C behaves exactly like reserved opcode F (single-cycle, result 0, flags from 0) and no multiplier logic is built. SHL/SHR remain.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams `ALU_ADD` … `ALU_RSV`;
  - flag bit positions `FLG_C`=0, `FLG_V`=1, `FLG_Z`=2, `FLG_N`=3;
  - FSM state enum `{IDLE, BUSY, DONE}`.
- Sub-module `alu_seq_engine`: the iterative multiply/shift datapath with counter, start/done handshake, and latched operands. The parent keeps the register file, flags, single-cycle ALU and commit muxing.

## Test plan
All scenarios use WIDTH=16, NREGS=8.
1. r1=0x7FFF, r2=0x0001; ADD a=1, b=2, d=4, `wr_flags` -> `res_valid` same cycle; r4=0x8000; flags=0x000A.
2. r5=0x0005; CMP a=5, `sel_inp`, `t16`=5, `wr_flags`, `wr_reg` -> r-file unchanged; flags=0x0004; `wr_pc`=0 even with d=3.
3. With `ALU_SEQ_MUL_EN`: MUL of 0x0100 by 0x0100 -> `in_ready` low 17 cycles; commit at edge 17; d=0x0000; flags=0x0005. Without the macro: single-cycle, d=0.
4. SHL a=0x9001 by 3 -> 3 BUSY cycles, then d=0x8008, flags=0x0008. Shift by 0 -> commit at edge 1, d=a.
5. MOV imm 0x1234 to d=2 without `wr_flags` -> flags=0x1234. MOV to d=3 -> `wr_pc`=1 for one cycle.
6. Assert `rst_n` low during MUL BUSY -> no `res_valid`; destination and flags are 0; `in_ready`=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and sequencer states for the alu_ex_seq execute stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_MOV   = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_CMP   = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_OR    = 4'h5;
    localparam logic [3:0] ALU_XOR   = 4'h6;
    localparam logic [3:0] ALU_TST   = 4'h7;
    localparam logic [3:0] ALU_SEXT8 = 4'h8;
    localparam logic [3:0] ALU_NSWP  = 4'h9;
    localparam logic [3:0] ALU_LSR1  = 4'hA;
    localparam logic [3:0] ALU_LSL1  = 4'hB;
    localparam logic [3:0] ALU_MUL   = 4'hC;
    localparam logic [3:0] ALU_SHL   = 4'hD;
    localparam logic [3:0] ALU_SHR   = 4'hE;
    localparam logic [3:0] ALU_RSV   = 4'hF;

    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/alu_seq_engine.sv
// Iterative multiply / multi-bit shift engine with its own IDLE/BUSY/DONE sequencer.
// The shift-add multiplier is only built when ALU_SEQ_MUL_EN is defined.
module alu_seq_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LOGW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
`ifdef ALU_SEQ_MUL_EN
    input  logic [WIDTH-1:0] i_b,
`endif
    input  logic [LOGW-1:0]  i_shamt,
    output logic             o_idle,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    localparam int CW = LOGW + 1;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cntInit;
    logic [WIDTH-1:0] r_lo;
    logic            r_carry;
    logic            r_left;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_mcand;
    logic             r_mul;
    logic             w_isMul;
    logic [WIDTH:0]   w_sum;

    // Product register {r_hi, r_lo}: r_lo starts as the multiplier and is shifted out as the product fills in
    assign w_isMul   = (i_op == ALU_MUL);
    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_cntInit = w_isMul ? CW'(WIDTH) : {1'b0, i_shamt};
`else
    assign w_cntInit = {1'b0, i_shamt};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A zero iteration count skips BUSY so shift-by-0 commits one edge after accept
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (w_cntInit == '0) ? DONE : BUSY;
            BUSY:    if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_lo    <= '0;
            r_carry <= 1'b0;
            r_left  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_hi    <= '0;
            r_mcand <= '0;
            r_mul   <= 1'b0;
`endif
        end else if (r_state == IDLE && i_start) begin
            r_cnt   <= w_cntInit;
            r_carry <= 1'b0;
            r_left  <= (i_op == ALU_SHL);
`ifdef ALU_SEQ_MUL_EN
            r_mul   <= w_isMul;
            r_hi    <= '0;
            r_mcand <= i_a;
            r_lo    <= w_isMul ? i_b : i_a;
`else
            r_lo    <= i_a;
`endif
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
            if (r_mul) begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end else
`endif
            if (r_left) begin
                r_carry <= r_lo[WIDTH-1];
                r_lo    <= {r_lo[WIDTH-2:0], 1'b0};
            end else begin
                r_carry <= r_lo[0];
                r_lo    <= {1'b0, r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_idle   = (r_state == IDLE);
    assign o_done   = (r_state == DONE);
    assign o_result = r_lo;
`ifdef ALU_SEQ_MUL_EN
    assign o_carry  = r_mul ? (|r_hi) : r_carry;
`else
    assign o_carry  = r_carry;
`endif

endmodule

// File: rtl/alu_ex_seq.sv
// Execute stage: register file, flags, single-cycle ALU and commit muxing around alu_seq_engine.
// Define ALU_SEQ_MUL_EN to make opcode C a multi-cycle multiply; otherwise it acts as the reserved opcode.
module alu_ex_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NREGS     = 8,
    parameter int FLAGS_IDX = 2,
    parameter int PC_IDX    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               alu_f,
    input  logic [$clog2(NREGS)-1:0] a_idx,
    input  logic [$clog2(NREGS)-1:0] b_idx,
    input  logic [$clog2(NREGS)-1:0] d_idx,
    input  logic                     wr_reg,
    input  logic                     wr_flags,
    input  logic [WIDTH-1:0]         t16,
    input  logic                     sel_inp,
    output logic [WIDTH-1:0]         flags,
    output logic [WIDTH-1:0]         d_val,
    output logic [WIDTH-1:0]         mem_data,
    output logic                     wr_pc,
    output logic                     res_valid
);

    localparam int IW   = $clog2(NREGS);
    localparam int LOGW = $clog2(WIDTH);
    localparam int M    = WIDTH - 1;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_flags;
    logic [IW-1:0]    r_dIdx;
    logic             r_wrReg;
    logic             r_wrFlags;

    logic [WIDTH-1:0] w_a, w_sel;
    logic [WIDTH:0]   w_sum, w_diff;
    logic             w_addV, w_subV;
    logic [WIDTH-1:0] w_aluRes;
    logic             w_aluC, w_aluV;
    logic             w_isMulti, w_isCmpTst, w_accept, w_start;
    logic             w_engIdle, w_engDone, w_engC;
    logic [WIDTH-1:0] w_engRes;
    logic             w_commit, w_wrReg, w_wrFlags, w_c, w_v;
    logic [WIDTH-1:0] w_res, w_flagVec;
    logic [IW-1:0]    w_idx;

    assign w_a    = r_regs[a_idx];
    assign w_sel  = sel_inp ? t16 : r_regs[b_idx];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_sel};
    assign w_diff = {1'b0, w_a} - {1'b0, w_sel};
    assign w_addV = (w_a[M] == w_sel[M]) && (w_sum[M] != w_a[M]);
    assign w_subV = (w_a[M] != w_sel[M]) && (w_diff[M] != w_a[M]);

    always_comb begin
        w_aluRes = '0;
        w_aluC   = 1'b0;
        w_aluV   = 1'b0;
        case (alu_f)
            ALU_ADD:          begin w_aluRes = w_sum[M:0];  w_aluC = w_sum[WIDTH];  w_aluV = w_addV; end
            ALU_MOV:          begin w_aluRes = w_sel;       w_aluV = w_addV; end
            ALU_SUB, ALU_CMP: begin w_aluRes = w_diff[M:0]; w_aluC = w_diff[WIDTH]; w_aluV = w_subV; end
            ALU_AND, ALU_TST: w_aluRes = w_a & w_sel;
            ALU_OR:           w_aluRes = w_a | w_sel;
            ALU_XOR:          w_aluRes = w_a ^ w_sel;
            ALU_SEXT8:        w_aluRes = {{(WIDTH-8){w_sel[7]}}, w_sel[7:0]};
            ALU_NSWP:         w_aluRes = {{(WIDTH-8){1'b0}}, w_sel[3:0], w_sel[7:4]};
            ALU_LSR1:         begin w_aluRes = {1'b0, w_sel[M:1]};   w_aluC = w_sel[0]; end
            ALU_LSL1:         begin w_aluRes = {w_sel[M-1:0], 1'b0}; w_aluC = w_sel[M]; end
            default:          ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign w_isMulti = (alu_f == ALU_SHL) | (alu_f == ALU_SHR) | (alu_f == ALU_MUL);
`else
    assign w_isMulti = (alu_f == ALU_SHL) | (alu_f == ALU_SHR);
`endif
    assign w_isCmpTst = (alu_f == ALU_CMP) | (alu_f == ALU_TST);
    assign w_accept   = in_valid & w_engIdle;
    assign w_start    = w_accept & w_isMulti;

    alu_seq_engine #(.WIDTH(WIDTH)) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_op     (alu_f),
        .i_a      (w_a),
`ifdef ALU_SEQ_MUL_EN
        .i_b      (w_sel),
`endif
        .i_shamt  (w_sel[LOGW-1:0]),
        .o_idle   (w_engIdle),
        .o_done   (w_engDone),
        .o_result (w_engRes),
        .o_carry  (w_engC)
    );

    // Commit source: the live decode for single-cycle ops, the latched fields while the engine is in DONE
    always_comb begin
        w_commit  = w_accept & ~w_isMulti;
        w_res     = w_aluRes;
        w_c       = w_aluC;
        w_v       = w_aluV;
        w_idx     = d_idx;
        w_wrReg   = wr_reg & ~w_isCmpTst;
        w_wrFlags = wr_flags;
        if (w_engDone) begin
            w_commit  = 1'b1;
            w_res     = w_engRes;
            w_c       = w_engC;
            w_v       = 1'b0;
            w_idx     = r_dIdx;
            w_wrReg   = r_wrReg;
            w_wrFlags = r_wrFlags;
        end
        w_flagVec        = '0;
        w_flagVec[FLG_C] = w_c;
        w_flagVec[FLG_V] = w_v;
        w_flagVec[FLG_Z] = (w_res == '0);
        w_flagVec[FLG_N] = w_res[M];
    end

    // An explicit flags load takes priority over the flags register being a register-write target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_flags   <= '0;
            r_dIdx    <= '0;
            r_wrReg   <= 1'b0;
            r_wrFlags <= 1'b0;
        end else begin
            if (w_start) begin
                r_dIdx    <= d_idx;
                r_wrReg   <= wr_reg;
                r_wrFlags <= wr_flags;
            end
            if (w_commit && w_wrReg) r_regs[w_idx] <= w_res;
            if (w_commit && w_wrFlags)
                r_flags <= w_flagVec;
            else if (w_commit && w_wrReg && (w_idx == IW'(FLAGS_IDX)))
                r_flags <= w_res;
        end
    end

    assign in_ready  = w_engIdle;
    assign res_valid = w_commit;
    assign d_val     = w_commit ? w_res : '0;
    assign wr_pc     = w_commit & w_wrReg & (w_idx == IW'(PC_IDX));
    assign mem_data  = r_regs[b_idx];
    assign flags     = r_flags;

endmodule
